// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : registered 8-op ALU with valid/ready handshake and serial shifts
// Rev 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;

  logic               accept;
  logic               is_shift;
  logic               load;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   work_next;
  logic               shift_out;

  assign accept   = in_valid & in_ready;
  assign k        = b[SHAMT_W-1:0];
  assign is_shift = (sel == OP_SHL) || (sel == OP_SHR);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an unknown sel fails is_shift and so behaves as add
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift && (k != '0)) state_d = S_SHIFT;
          else                       state_d = S_DONE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_ONE) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath next values
  always_comb begin
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    load      = 1'b0;
    sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff      = {1'b0, a} - {1'b0, b};
    shift_out = left_q ? work_q[WIDTH-1] : work_q[0];
    work_next = left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};

    if (accept) begin
      case (sel)
        OP_SUB: begin
          load     = 1'b1;
          result_d = diff[WIDTH-1:0];
          carry_d  = diff[WIDTH];
          ovf_d    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
        OP_AND, OP_OR, OP_XOR, OP_NOT: begin
          load    = 1'b1;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          case (sel)
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_XOR:  result_d = a ^ b;
            default: result_d = ~a;
          endcase
        end
        OP_SHL, OP_SHR: begin
          work_d = a;
          cnt_d  = k;
          left_d = (sel == OP_SHL);
          // Zero-length shift completes immediately; otherwise flags wait for the last bit
          if (k == '0) begin
            load     = 1'b1;
            result_d = a;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
          end
        end
        default: begin
          load     = 1'b1;
          result_d = sum[WIDTH-1:0];
          carry_d  = sum[WIDTH];
          ovf_d    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
      endcase
    end else if (state_q == S_SHIFT) begin
      work_d = work_next;
      cnt_d  = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        load     = 1'b1;
        result_d = work_next;
        carry_d  = shift_out;
        ovf_d    = 1'b0;
      end
    end

    zero_d = load ? (result_d == '0)        : zero_q;
    neg_d  = load ? result_d[WIDTH-1]       : neg_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule
`default_nettype wire
